// File: rtl/pipeline_output_capture.sv
// Credit-based result capture buffer behind a fixed-latency, non-stallable pipeline.
// Optional same-cycle bypass from pipe_data when empty: define PIPE_CAPTURE_BYPASS_EN.
module pipeline_output_capture #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [$clog2(DEPTH):0] credits
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cred_q, cred_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic empty;
  logic last;
  logic issue;
  logic pop;
  logic pop_mem;
  logic push;
  logic byp;

  assign empty    = (cnt_q == '0);
  assign last     = vld_q[LATENCY-1];
  assign in_ready = !rst && (cred_q != '0);
  assign issue    = in_valid && in_ready;
  assign credits  = cred_q;

`ifdef PIPE_CAPTURE_BYPASS_EN
  assign byp      = empty && last;
  assign out_data = empty ? pipe_data : mem_q[rd_q];
`else
  assign byp      = 1'b0;
  assign out_data = mem_q[rd_q];
`endif

  assign out_valid = !rst && (!empty || byp);
  assign pop       = out_valid && out_ready;
  assign pop_mem   = pop && !empty;
  // A bypassed result consumed this cycle never touches storage
  assign push      = last && !rst && !(byp && out_ready);

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = issue;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = (wr_q == PTR_MAX) ? '0 : wr_q + 1'b1;
    if (pop_mem) rd_d = (rd_q == PTR_MAX) ? '0 : rd_q + 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop_mem})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    cred_d = cred_q;
    case ({issue, pop})
      2'b10:   cred_d = cred_q - 1'b1;
      2'b01:   cred_d = cred_q + 1'b1;
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      cred_q <= CRED_MAX;
    end else begin
      vld_q  <= vld_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      cred_q <= cred_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= pipe_data;
  end

endmodule

// File: tb/tb_pipeline_output_capture.sv
// Directed vector table plus random scoreboard run for pipeline_output_capture.
module tb_pipeline_output_capture;

  typedef struct {
    logic        r;
    logic        iv;
    logic        ordy;
    logic [31:0] tag;
    logic        e_rdy;
    logic        e_ov;
    logic [2:0]  e_cred;
    logic        ck_cred;
    logic [31:0] e_data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pipe_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  credits;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic        vld_p [2];
  logic [31:0] tag_p [2];
  logic [31:0] q [$];
  rec_t        tbl [$];

  pipeline_output_capture #(
    .DATA_WIDTH(32),
    .LATENCY(2),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pipe_data(pipe_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .credits(credits)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(
    logic r, logic iv, logic ordy, logic [31:0] tag,
    logic rdy, logic ov, logic [2:0] cr, logic ckc,
    logic [31:0] d);
    rec_t x;
    x.r = r; x.iv = iv; x.ordy = ordy; x.tag = tag;
    x.e_rdy = rdy; x.e_ov = ov; x.e_cred = cr;
    x.ck_cred = ckc; x.e_data = d;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  // Stand-in for the stitched pipeline: keeps running across reset
  task automatic drive(logic r, logic iv, logic ordy);
    rst       = r;
    in_valid  = iv;
    out_ready = ordy;
    pipe_data = vld_p[1] ? tag_p[1] : (32'hDEAD_0000 | cyc);
  endtask

  task automatic advance(logic issue, logic [31:0] tag,
                         logic pop, logic model);
    @(posedge clk);
    #1;
    if (model) begin
      if (pop) void'(q.pop_front());
      if (vld_p[1]) q.push_back(tag_p[1]);
    end
    vld_p[1] = vld_p[0];
    tag_p[1] = tag_p[0];
    vld_p[0] = issue;
    tag_p[0] = tag;
    cyc++;
  endtask

  initial begin
    logic        iv, ordy, issue, pop;
    logic [31:0] tag;
    int          infl;
    int          e_cred;

    vld_p[0] = 1'b0; vld_p[1] = 1'b0;
    tag_p[0] = '0;   tag_p[1] = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    pipe_data = '0;

    // single issue after reset, result 7
    tbl.push_back(mk(1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 0,0,4,1, 0));
    tbl.push_back(mk(0,1,1,7, 1,0,4,1, 0));
    tbl.push_back(mk(0,0,1,0, 1,0,3,1, 0));
    tbl.push_back(mk(0,0,1,0, 1,0,3,1, 0));
    tbl.push_back(mk(0,0,1,0, 1,1,3,1, 7));
    tbl.push_back(mk(0,0,1,0, 1,0,4,1, 0));
    // fill with out_ready low: four issues then blocked
    tbl.push_back(mk(0,1,0,1, 1,0,4,1, 0));
    tbl.push_back(mk(0,1,0,2, 1,0,3,1, 0));
    tbl.push_back(mk(0,1,0,3, 1,0,2,1, 0));
    tbl.push_back(mk(0,1,0,4, 1,1,1,1, 1));
    tbl.push_back(mk(0,1,0,0, 0,1,0,1, 1));
    tbl.push_back(mk(0,1,0,0, 0,1,0,1, 1));
    tbl.push_back(mk(0,1,0,0, 0,1,0,1, 1));
    tbl.push_back(mk(0,1,0,0, 0,1,0,1, 1));
    // full buffer, then continuous issue and drain
    tbl.push_back(mk(0,1,1,0,  0,1,0,1, 1));
    tbl.push_back(mk(0,1,1,5,  1,1,1,1, 2));
    tbl.push_back(mk(0,1,1,6,  1,1,1,1, 3));
    tbl.push_back(mk(0,1,1,7,  1,1,1,1, 4));
    tbl.push_back(mk(0,1,1,8,  1,1,1,1, 5));
    tbl.push_back(mk(0,1,1,9,  1,1,1,1, 6));
    tbl.push_back(mk(0,1,1,10, 1,1,1,1, 7));
    tbl.push_back(mk(0,1,1,11, 1,1,1,1, 8));
    tbl.push_back(mk(0,0,1,0,  1,1,1,1, 9));
    tbl.push_back(mk(0,0,1,0,  1,1,2,1, 10));
    tbl.push_back(mk(0,0,1,0,  1,1,3,1, 11));
    tbl.push_back(mk(0,0,1,0,  1,0,4,1, 0));
    // three in flight, one-cycle reset, late results ignored
    tbl.push_back(mk(0,1,0,12, 1,0,4,1, 0));
    tbl.push_back(mk(0,1,0,13, 1,0,3,1, 0));
    tbl.push_back(mk(0,1,0,14, 1,0,2,1, 0));
    tbl.push_back(mk(1,0,0,0,  0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,0,  1,0,4,1, 0));
    tbl.push_back(mk(0,0,1,0,  1,0,4,1, 0));
    tbl.push_back(mk(0,0,1,0,  1,0,4,1, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].iv, tbl[i].ordy);
      @(negedge clk);
      chk("in_ready", in_ready, tbl[i].e_rdy);
      chk("out_valid", out_valid, tbl[i].e_ov);
      if (tbl[i].ck_cred)
        chk("credits", credits, tbl[i].e_cred);
      if (tbl[i].e_ov)
        chk("out_data", out_data, tbl[i].e_data);
      issue = tbl[i].iv && tbl[i].e_rdy && !tbl[i].r;
      advance(issue, tbl[i].tag, 1'b0, 1'b0);
    end

    // random traffic against a queue model
    tag = 32'd100;
    for (int k = 0; k < 10000; k++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      drive(1'b0, iv, ordy);
      @(negedge clk);
      infl   = int'(vld_p[0]) + int'(vld_p[1]);
      e_cred = 4 - q.size() - infl;
      chk("rnd_credits", credits, e_cred);
      chk("rnd_in_ready", in_ready, e_cred != 0);
      chk("rnd_out_valid", out_valid, q.size() != 0);
      if (q.size() != 0)
        chk("rnd_out_data", out_data, q[0]);
      issue = iv && (e_cred != 0);
      pop   = ordy && (q.size() != 0);
      advance(issue, tag, pop, 1'b1);
      if (issue) tag++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_output_capture.md
PIPELINE_OUTPUT_CAPTURE -- requirements
Module: pipeline_output_capture

Interface
REQ-001 The module SHALL have the parameter DATA_WIDTH, default 32, which sets the result payload width.
REQ-002 The module SHALL have the parameter LATENCY, default 2, which is the fixed cycle count from issue to result at pipe_data (range 1..8).
REQ-003 The module SHALL have the parameter DEPTH, default 4, which is the result buffer entry count (power of two, DEPTH >= LATENCY).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 in_valid  input  1  the producer requests to issue one operation into the stitched pipeline.
REQ-007 in_ready  output  1  issue permitted this cycle.
REQ-008 pipe_data  input  DATA_WIDTH  result from the non-stallable, fixed-latency stitched pipeline.
REQ-009 out_valid  output  1  buffered result available.
REQ-010 out_data  output  DATA_WIDTH  buffered result, oldest first.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 credits  output  $clog2(DEPTH)+1  DEPTH minus (buffer occupancy plus in-flight count).

Function
REQ-013 An issue SHALL occur when in_valid and in_ready are both high in the same cycle.
REQ-014 in_ready SHALL equal (credits != 0) and SHALL be combinational from registered state only, with no path from in_valid or out_ready.
REQ-015 A LATENCY-bit valid shift register SHALL shift each cycle with the issue bit entering stage 0; its last stage SHALL mark pipe_data as a valid result.
REQ-016 When the last shift stage is 1, pipe_data SHALL be written into the buffer tail that cycle; pipe_data SHALL be ignored otherwise.
REQ-017 A pop SHALL occur when out_valid and out_ready are both high; out_data SHALL present the head entry, and out_valid SHALL be high whenever the buffer is non-empty (absent bypass, REQ-027).
REQ-018 A push and a pop in the same cycle SHALL leave occupancy unchanged, including when the buffer is full or holds one entry.
REQ-019 The credit counter SHALL decrement on an issue, increment on a pop, and stay unchanged when both occur in the same cycle.
REQ-020 The credit counter SHALL stay within 0..DEPTH; by construction a push never targets a full buffer.
REQ-021 Buffer pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or the occupancy count.
REQ-022 Result ordering SHALL equal issue ordering; no result is dropped or duplicated.

Reset
REQ-023 While rst is high, the valid shift register, buffer pointers and occupancy SHALL clear to 0, credits SHALL load DEPTH, out_valid SHALL be 0, and in_ready SHALL be 0.
REQ-024 Operations in flight at reset assertion SHALL be discarded; pipe_data arriving after reset deassertion SHALL be ignored until a post-reset issue reaches the last stage.
REQ-025 Buffer storage contents SHALL NOT require reset; out_data is don't-care while out_valid is 0.

Configuration
REQ-026 The macro PIPE_CAPTURE_BYPASS_EN SHALL select the bypass feature at compile time.
REQ-027 With PIPE_CAPTURE_BYPASS_EN defined, when the buffer is empty and the last shift stage is 1, out_valid SHALL be 1 and out_data SHALL equal pipe_data combinationally in that cycle; if out_ready is also high, the result SHALL be consumed without a write, and credits SHALL increment.
REQ-028 Without PIPE_CAPTURE_BYPASS_EN, every result SHALL be written first and appear at out_data no earlier than the cycle after capture, giving an issue-to-out_valid latency of LATENCY+1.

Verification
REQ-029 Reset, then a single issue at cycle 0 with pipe_data=0x00000007 at cycle 2 and out_ready=1 -> out_valid at cycle 3 with out_data=0x00000007 (cycle 2 with bypass), after which credits return to 4.
REQ-030 out_ready=0 and in_valid held high -> exactly 4 issues accepted, in_ready=0 from the 5th cycle, credits=0, buffer holds results 1,2,3,4 in order, and pipe_data when no stage is valid is never captured.
REQ-031 Full buffer, then out_ready=1 and in_valid=1 continuously -> one issue and one pop per cycle, credits steady at 0 or 1, output sequence gap-free and in order.
REQ-032 Three issues in flight, then rst pulsed for 1 cycle -> out_valid=0, credits=4, and no stale result appears afterward.
REQ-033 Random in_valid/out_ready at 50% for 10k cycles with pipe_data set to the issue index -> scoreboard match, credits == 4 - occupancy - inflight every cycle, and no overflow.
